// File: rtl/tap_player.sv
// tap_player: datasette playback; turns TAP pulse-length bytes into active-low FLAG read pulses, gated by motor and PLAY key.
// Latency: tap_ready is combinational from state; flag_n falls the clk after the N-th running phi2 tick of an N-tick interval.
// Backpressure: bytes are taken only in FETCH (and LONG0-2) while the motor is up to speed; define TAP_V1_LONG_EN for TAP v1 24-bit long pulses.
module tap_player #(
    parameter int MOTOR_DELAY = 16,
    parameter int FLAG_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       phi2_en,
    input  logic       motor_n,
    input  logic       play_key,
    input  logic [7:0] tap_data,
    input  logic       tap_valid,
    output logic       tap_ready,
    output logic       sense,
    output logic       flag_n,
    output logic       underrun
);
    localparam int SPIN_W  = (MOTOR_DELAY > 0) ? $clog2(MOTOR_DELAY + 1) : 1;
    localparam int PULSE_W = (FLAG_W > 0) ? $clog2(FLAG_W + 1) : 1;
    localparam logic [SPIN_W-1:0]  SPIN_LOAD  = SPIN_W'(MOTOR_DELAY);
    localparam logic [PULSE_W-1:0] PULSE_LOAD = PULSE_W'(FLAG_W);

    typedef enum logic [2:0] {IDLE, FETCH, LONG0, LONG1, LONG2, COUNT} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [23:0]         r_cnt;
    logic [23:0]         w_cnt_nxt;
    logic [SPIN_W-1:0]   r_spin;
    logic                r_motor_q;
    logic [PULSE_W-1:0]  r_pulse;
    logic                r_sense;
    logic                r_underrun;
    logic                w_motor_on;
    logic                w_motor_rise;
    logic                w_running;
    logic                w_fetching;
    logic                w_accept;
    logic                w_pulse_start;

    assign w_motor_on   = ~motor_n & play_key;
    assign w_motor_rise = w_motor_on & ~r_motor_q;
    // The clk of the motor rise is not running: the spin counter reloads on that edge.
    assign w_running    = w_motor_on & r_motor_q & (r_spin == '0);
`ifdef TAP_V1_LONG_EN
    assign w_fetching   = (r_state == FETCH) | (r_state == LONG0) | (r_state == LONG1) | (r_state == LONG2);
`else
    assign w_fetching   = (r_state == FETCH);
`endif
    // Stream is held off while the tape is not moving so state stays frozen.
    assign tap_ready    = w_fetching & w_running;
    assign w_accept     = tap_valid & tap_ready;
    assign sense        = r_sense;
    assign flag_n       = (r_pulse == '0);
    assign underrun     = r_underrun;

    // Next-state and interval counter load/decrement.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pulse_start = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_running) w_state_nxt = FETCH;
            end
            FETCH: begin
                if (w_accept) begin
                    if (tap_data != 8'd0) begin
                        w_cnt_nxt   = {13'd0, tap_data, 3'd0};
                        w_state_nxt = COUNT;
                    end else begin
`ifdef TAP_V1_LONG_EN
                        w_cnt_nxt   = 24'd0;
                        w_state_nxt = LONG0;
`else
                        w_cnt_nxt   = 24'd2048;
                        w_state_nxt = COUNT;
`endif
                    end
                end
            end
`ifdef TAP_V1_LONG_EN
            LONG0: begin
                if (w_accept) begin
                    w_cnt_nxt   = {r_cnt[23:8], tap_data};
                    w_state_nxt = LONG1;
                end
            end
            LONG1: begin
                if (w_accept) begin
                    w_cnt_nxt   = {r_cnt[23:16], tap_data, r_cnt[7:0]};
                    w_state_nxt = LONG2;
                end
            end
            LONG2: begin
                if (w_accept) begin
                    // A zero-length long pulse still needs one tick to produce a pulse.
                    if ({tap_data, r_cnt[15:0]} == 24'd0) w_cnt_nxt = 24'd1;
                    else                                  w_cnt_nxt = {tap_data, r_cnt[15:0]};
                    w_state_nxt = COUNT;
                end
            end
`endif
            COUNT: begin
                if (w_running && phi2_en) begin
                    if (r_cnt <= 24'd1) begin
                        w_cnt_nxt     = 24'd0;
                        w_pulse_start = 1'b1;
                        w_state_nxt   = FETCH;
                    end else begin
                        w_cnt_nxt = r_cnt - 24'd1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and interval counter; reset abandons any interval in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Motor spin-up: each off->on transition restarts the delay count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_motor_q <= 1'b0;
            r_spin    <= '0;
        end else begin
            r_motor_q <= w_motor_on;
            if (w_motor_rise)                 r_spin <= SPIN_LOAD;
            else if (phi2_en && r_spin != '0) r_spin <= r_spin - SPIN_W'(1);
        end
    end

    // FLAG pulse timer runs on phi2 regardless of motor; a new pulse restarts it.
    always_ff @(posedge clk) begin
        if (reset)                            r_pulse <= '0;
        else if (w_pulse_start)               r_pulse <= PULSE_LOAD;
        else if (phi2_en && r_pulse != '0)    r_pulse <= r_pulse - PULSE_W'(1);
    end

    // Cassette sense mirrors the PLAY key, one clk late.
    always_ff @(posedge clk) begin
        if (reset) r_sense <= 1'b1;
        else       r_sense <= ~play_key;
    end

    // Sticky starvation flag, cleared by releasing PLAY.
    always_ff @(posedge clk) begin
        if (reset || !play_key)                                   r_underrun <= 1'b0;
        else if (w_fetching && w_running && phi2_en && !tap_valid) r_underrun <= 1'b1;
    end
endmodule

// File: doc/tap_player.md
TAP_PLAYER -- requirements
Module: tap_player

Interface
Parameters:
REQ-001 SHALL provide parameter MOTOR_DELAY, default 16: phi2_en ticks of motor spin-up before playback counting resumes.
REQ-002 SHALL provide parameter FLAG_W, default 4: phi2_en ticks that flag_n is held low per tape pulse.
Ports:
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port phi2_en  input  1  one-clk-wide strobe per CPU cycle; all timing counts in these ticks.
REQ-006 SHALL have port motor_n  input  1  CPU port bit 5; 0 = motor on.
REQ-007 SHALL have port play_key  input  1  1 = PLAY held down.
REQ-008 SHALL have port tap_data  input  8  next TAP stream byte.
REQ-009 SHALL have port tap_valid  input  1  tap_data valid.
REQ-010 SHALL have port tap_ready  output  1  byte accepted when tap_valid and tap_ready are high on the same clk.
REQ-011 SHALL have port sense  output  1  to CPU port input bit 4; 0 = key pressed.
REQ-012 SHALL have port flag_n  output  1  read pulse to CIA1 FLAG, active low.
REQ-013 SHALL have port underrun  output  1  sticky stream-starvation flag.

Function
REQ-014 SHALL register sense = ~play_key, updated every clk.
REQ-015 SHALL define motor_on = ~motor_n & play_key; on each 0->1 transition load spin counter with MOTOR_DELAY, decrement once per phi2_en to 0; running = motor_on & (spin == 0).
REQ-016 SHALL implement states IDLE, FETCH, LONG0, LONG1, LONG2, COUNT.
REQ-017 IDLE -> FETCH when running; otherwise stay.
REQ-018 tap_ready SHALL be high only in FETCH, LONG0, LONG1, LONG2; byte transfer is independent of phi2_en.
REQ-019 FETCH, nonzero byte b accepted: load 24-bit counter with b*8, go COUNT.
REQ-020 FETCH, zero byte accepted: behaviour per REQ-030/REQ-031.
REQ-021 LONG0/1/2 SHALL collect bytes little-endian into counter bits 7:0, 15:8, 23:16, then go COUNT; an assembled value of 0 SHALL load 1.
REQ-022 COUNT: decrement counter on each phi2_en while running; a length-N interval lasts exactly N running ticks.
REQ-023 On the tick where counter goes 1 -> 0: start flag pulse (flag_n low for FLAG_W phi2_en ticks, starting next clk) and go FETCH in the same clk.
REQ-024 Pulse timer SHALL be independent of running; an in-progress pulse completes even if the motor stops. A new pulse while one is active SHALL restart the timer.
REQ-025 When running drops: counter and state freeze (no ticks consumed), resume unchanged when running returns after spin-up.
REQ-026 underrun SHALL set when in FETCH/LONG0-2, running, phi2_en high, and tap_valid low; SHALL clear only when play_key is low or on reset.
REQ-027 Counter SHALL be 24 bits; b*8 maximum 2040; no wrap beyond 0.

Reset
REQ-028 reset SHALL force: state IDLE, counter 0, spin counter 0, pulse timer 0, flag_n 1, tap_ready 0, underrun 0, sense 1.
REQ-029 reset mid-interval or mid-pulse SHALL abort immediately; no residual flag pulse after reset deasserts.

Configuration
REQ-030 With TAP_V1_LONG_EN defined: zero byte in FETCH -> LONG0 (TAP v1 24-bit overflow format).
REQ-031 Without TAP_V1_LONG_EN: zero byte in FETCH loads 2048 and goes COUNT (TAP v0); LONG states never entered, tap_ready never high outside FETCH.

Verification
REQ-032 Reset asserted with play_key=1, motor_n=0 -> sense=1, flag_n=1, tap_ready=0 during reset; sense=0 one clk after release.
REQ-033 MOTOR_DELAY=16, motor on, byte 0x30 presented -> tap_ready high after 16 ticks; flag_n falls 384 running ticks after acceptance, low exactly 4 ticks.
REQ-034 TAP_V1_LONG_EN, bytes 00 10 27 00 -> interval 10000 ticks; without macro, 00 -> 2048 ticks then 0x10 -> 128 ticks.
REQ-035 motor_n=1 for 500 ticks in mid-interval of 0x30 -> flag_n delayed by 500+16 ticks vs uninterrupted run.
REQ-036 tap_valid low in FETCH for 3 ticks while running -> underrun=1, stays 1 after data resumes, clears when play_key=0.
